// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch path: response entry and illegal-instruction constant.
package ifetch_pkg;

    localparam int IR_W = 32;
    localparam logic [IR_W-1:0] ILLEGAL_IR = 32'h0000_0000;

    typedef struct packed {
        logic            err;
        logic [IR_W-1:0] ir;
    } ifetch_rsp_t;

endpackage

// File: rtl/ifetch_sram_ctrl_if.sv
// Fetch request/response interface between the fetch unit (master) and its instruction source (slave).
interface ifetch_if_t #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic          req_vld;
    logic          req_rdy;
    logic [AW-1:0] req_pc;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_ir;

    modport master (
        output req_vld, req_pc, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_ir
    );

    modport slave (
        input  req_vld, req_pc, rsp_rdy,
        output req_rdy, rsp_vld, rsp_ir
    );

endinterface

// File: rtl/ifetch_rsp_fifo.sv
// Two-entry FIFO of fetch responses; head is visible combinationally while not empty.
module ifetch_rsp_fifo
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  ifetch_rsp_t push_data_i,
    input  logic        pop_i,
    output ifetch_rsp_t head_o,
    output logic        empty_o,
    output logic        full_o,
    output logic [1:0]  cnt_o
);

    ifetch_rsp_t mem_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] cnt_q;

    // NOTE: pointers and count use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides whether an entry is live.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/ifetch_sram_ctrl.sv
// Serves fetch requests from a 1-cycle-latency SRAM with a bypass path and a 2-entry response buffer.
module ifetch_sram_ctrl
    import ifetch_pkg::*;
#(
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter int            DEPTH_LOG2 = 12,
    parameter logic [AW-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ifetch_if_t.slave             ifetch,
    output logic                  sram_cs,
    output logic [DEPTH_LOG2-1:0] sram_addr,
    input  logic [DW-1:0]         sram_rdata,
    output logic [7:0]            err_cnt
);

    logic        err_req, req_hsk, rsp_hsk;
    logic        inflight_q, inflight_err_q;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [1:0]  occ, occ_after;
    logic        fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [1:0]  fifo_cnt;
    ifetch_rsp_t s1_rsp, fifo_head, cur_rsp;

    assign err_req = (ifetch.req_pc[1:0] != 2'b00) |
                     (ifetch.req_pc[AW-1:DEPTH_LOG2+2] != BASE_ADDR[AW-1:DEPTH_LOG2+2]);

    assign req_hsk   = ifetch.req_vld & ifetch.req_rdy;
    assign sram_addr = ifetch.req_pc[DEPTH_LOG2+1:2];
    assign sram_cs   = req_hsk & ~err_req;

    // A request is in flight for exactly the one cycle the SRAM needs to return data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
            err_cnt_q      <= 8'h00;
        end else begin
            inflight_q     <= req_hsk;
            inflight_err_q <= err_req;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign s1_rsp.err = inflight_err_q;
    assign s1_rsp.ir  = inflight_err_q ? ILLEGAL_IR : sram_rdata;

    // Older buffered responses always go first; the bypass is used only when the buffer is empty.
    // NOTE: every combinational output gets a default first so no path leaves a latch behind.
    always_comb begin
        cur_rsp        = fifo_empty ? s1_rsp : fifo_head;
        ifetch.rsp_vld = ~fifo_empty | inflight_q;
        ifetch.rsp_ir  = '0;
        if (ifetch.rsp_vld) ifetch.rsp_ir = cur_rsp.ir;
    end

    assign rsp_hsk   = ifetch.rsp_vld & ifetch.rsp_rdy;
    assign fifo_push = inflight_q & ~(fifo_empty & ifetch.rsp_rdy);
    assign fifo_pop  = ~fifo_empty & rsp_hsk;

    // rsp_vld is a function of state only, so req_rdy may look at rsp_rdy without a loop.
    assign occ            = {1'b0, inflight_q} + fifo_cnt;
    assign occ_after      = occ - {1'b0, rsp_hsk};
    assign ifetch.req_rdy = (occ_after < 2'd2);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (rsp_hsk && cur_rsp.err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    assign err_cnt = err_cnt_q;

    ifetch_rsp_fifo u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (s1_rsp),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .cnt_o       (fifo_cnt)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_ifetch_sram_ctrl.sv
// Bench for ifetch_sram_ctrl: directed vectors plus a scoreboard monitor comparing every delivered response.
module tb_ifetch_sram_ctrl;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sram_cs;
    logic [11:0] sram_addr;
    logic [31:0] sram_rdata = 32'h0;
    logic [7:0]  err_cnt;

    logic [31:0] mem [4096];
    ifetch_rsp_t sb_q [$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_push  = 0;
    int n_pop   = 0;
    int exp_err = 0;

    ifetch_if_t #(.AW(32), .DW(32)) u_if ();

    ifetch_sram_ctrl #(
        .AW(32), .DW(32), .DEPTH_LOG2(12), .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ifetch     (u_if),
        .sram_cs    (sram_cs),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_cs) sram_rdata <= mem[sram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ifetch_rsp_t model(input logic [31:0] pc);
        ifetch_rsp_t r;
        r.err = (pc[1:0] != 2'b00) || (pc[31:14] != 18'h0);
        r.ir  = r.err ? 32'h0000_0000 : mem[pc[13:2]];
        return r;
    endfunction

    // Monitor: samples on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            exp_err = 0;
        end else begin
            check("err_cnt", 32'(err_cnt), 32'(exp_err));
            check("req_rdy_known", 32'($isunknown(u_if.req_rdy)), 32'd0);
            if (sb_q.size() == 0) check("rsp_without_req", 32'(u_if.rsp_vld), 32'd0);
            if (u_if.rsp_vld && u_if.rsp_rdy && sb_q.size() != 0) begin
                ifetch_rsp_t e;
                e = sb_q.pop_front();
                n_pop++;
                check("rsp_ir", u_if.rsp_ir, e.ir);
                if (e.err && exp_err < 255) exp_err++;
            end
            if (u_if.req_vld && u_if.req_rdy) begin
                sb_q.push_back(model(u_if.req_pc));
                n_push++;
            end
            check("occ_le_2", 32'(sb_q.size() > 2), 32'd0);
        end
    end

    task automatic set_in(input logic vld, input logic [31:0] pc, input logic rrdy);
        @(posedge clk);
        #1;
        u_if.req_vld = vld;
        u_if.req_pc  = pc;
        u_if.rsp_rdy = rrdy;
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        u_if.req_vld = 1'b0;
        u_if.req_pc  = 32'h0;
        u_if.rsp_rdy = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [31:0] words [4];
    int idx;

    initial begin
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        words[2] = 32'h0020_0113;
        words[3] = 32'h0030_0193;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
        for (int i = 0; i < 4; i++) mem[i] = words[i];

        u_if.req_vld = 1'b0;
        u_if.req_pc  = 32'h0;
        u_if.rsp_rdy = 1'b1;
        #3;
        check("rst_req_rdy", 32'(u_if.req_rdy), 32'd1);
        check("rst_rsp_vld", 32'(u_if.rsp_vld), 32'd0);
        check("rst_rsp_ir", u_if.rsp_ir, 32'h0);
        check("rst_sram_cs", 32'(sram_cs), 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        do_reset();

        // Streaming at full rate
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(i * 4), 1'b1);
            check("stream_req_rdy", 32'(u_if.req_rdy), 32'd1);
            check("stream_sram_cs", 32'(sram_cs), 32'd1);
            check("stream_sram_addr", 32'(sram_addr), 32'(i));
            if (i > 0) begin
                check("stream_rsp_vld", 32'(u_if.rsp_vld), 32'd1);
                check("stream_rsp_ir", u_if.rsp_ir, words[i-1]);
            end
        end
        set_in(1'b0, 32'h0, 1'b1);
        check("stream_last_vld", 32'(u_if.rsp_vld), 32'd1);
        check("stream_last_ir", u_if.rsp_ir, words[3]);
        set_in(1'b0, 32'h0, 1'b1);
        check("stream_idle_vld", 32'(u_if.rsp_vld), 32'd0);

        // Back-pressure: only two requests accepted while stalled
        do_reset();
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            set_in(1'b1, 32'(idx * 4), 1'b0);
            if (c >= 2) begin
                check("stall_req_rdy", 32'(u_if.req_rdy), 32'd0);
                check("stall_rsp_vld", 32'(u_if.rsp_vld), 32'd1);
                check("stall_rsp_ir", u_if.rsp_ir, words[0]);
            end
            if (u_if.req_rdy) idx++;
        end
        check("stall_accepted", 32'(idx), 32'd2);
        for (int c = 0; c < 20 && idx < 4; c++) begin
            set_in(1'b1, 32'(idx * 4), 1'b1);
            if (u_if.req_rdy) idx++;
        end
        check("stall_all_issued", 32'(idx), 32'd4);
        for (int c = 0; c < 5; c++) set_in(1'b0, 32'h0, 1'b1);
        check("stall_drained", 32'(sb_q.size()), 32'd0);
        check("stall_no_loss", 32'(n_pop), 32'(n_push));

        // Misaligned and out-of-range PCs
        do_reset();
        set_in(1'b1, 32'h0000_0002, 1'b1);
        check("err_a_cs", 32'(sram_cs), 32'd0);
        check("err_cnt_0", 32'(err_cnt), 32'd0);
        set_in(1'b1, 32'h0000_4000, 1'b1);
        check("err_b_cs", 32'(sram_cs), 32'd0);
        check("err_a_vld", 32'(u_if.rsp_vld), 32'd1);
        check("err_a_ir", u_if.rsp_ir, 32'h0);
        set_in(1'b0, 32'h0, 1'b1);
        check("err_b_vld", 32'(u_if.rsp_vld), 32'd1);
        check("err_b_ir", u_if.rsp_ir, 32'h0);
        check("err_cnt_1", 32'(err_cnt), 32'd1);
        set_in(1'b0, 32'h0, 1'b1);
        check("err_cnt_2", 32'(err_cnt), 32'd2);

        // Counter saturation
        do_reset();
        for (int c = 0; c < 300; c++) set_in(1'b1, 32'h0000_0001, 1'b1);
        for (int c = 0; c < 3; c++) set_in(1'b0, 32'h0, 1'b1);
        check("err_cnt_sat", 32'(err_cnt), 32'hFF);

        // Reset with two responses pending
        do_reset();
        set_in(1'b1, 32'h0, 1'b0);
        check("rstmid_acc0", 32'(u_if.req_rdy), 32'd1);
        set_in(1'b1, 32'h4, 1'b0);
        check("rstmid_acc1", 32'(u_if.req_rdy), 32'd1);
        @(posedge clk);
        #1 u_if.req_vld = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_rsp_vld", 32'(u_if.rsp_vld), 32'd0);
        check("rstmid_req_rdy", 32'(u_if.req_rdy), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            set_in(1'b0, 32'h0, 1'b1);
            check("rstmid_quiet", 32'(u_if.rsp_vld), 32'd0);
        end

        // Random traffic against the scoreboard
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int r;
            logic [31:0] pc;
            r = int'($urandom_range(0, 15));
            if (r == 0)      pc = ($urandom_range(0, 63) * 4) | 32'h2;
            else if (r == 1) pc = 32'h0000_4000 + $urandom_range(0, 63) * 4;
            else             pc = $urandom_range(0, 63) * 4;
            set_in(($urandom_range(0, 3) != 0), pc, ($urandom_range(0, 2) != 0));
        end
        for (int c = 0; c < 5; c++) set_in(1'b0, 32'h0, 1'b1);
        check("rand_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
